// File: rtl/neuron_op_engine_pkg.sv
// Shared definitions for the neuron operation engine and its control-register block.
// Holds the FSM encoding, activation codes, the Q8.8 format and register addresses.
package neuron_op_engine_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int FRAC_BITS_DEF = 8;
  localparam int ACC_W_DEF     = 40;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_IDX = 3'd1,
    S_WGT = 3'd2,
    S_INP = 3'd3,
    S_MAC = 3'd4,
    S_ACT = 3'd5,
    S_WR  = 3'd6
  } opState_t;

  typedef enum logic [1:0] {
    ACT_ID    = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_STEP  = 2'd2,
    ACT_CLAMP = 2'd3
  } actSel_t;

  localparam logic [15:0] ONE_Q88 = 16'h0100;

  // Register map seen by the control-register block on the cache side.
  localparam logic [15:0] REG_OFFSET       = 16'h8000;
  localparam logic [15:0] REG_INDEX_OFFSET = 16'h8001;
  localparam logic [15:0] REG_WEIGHT_OFF   = 16'h8002;
  localparam logic [15:0] REG_NUM_OPS      = 16'h8003;
  localparam logic [15:0] REG_DEST         = 16'h8004;
  localparam logic [15:0] REG_ACT_SEL      = 16'h8005;

endpackage

// File: rtl/neuron_op_engine_activation_unit.sv
// Combinational activation: rescale the accumulator out of the product format,
// saturate to the signed data range, then apply the selected nonlinearity.
module activation_unit
  import neuron_op_engine_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic        [1:0]        actFuncSel,
  output logic        [DATA_W-1:0] result
);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ONE = DATA_W'(ONE_Q88);

  logic signed [ACC_W-1:0] shifted;
  logic        [DATA_W-1:0] scaled;
  logic                     isNeg;
  logic                     isZero;

  assign shifted = acc >>> FRAC_BITS;

  always_comb begin
    scaled = shifted[DATA_W-1:0];
    if (shifted > MAX_V) begin
      scaled = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      scaled = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

  assign isNeg  = scaled[DATA_W-1];
  assign isZero = (scaled == '0);

  always_comb begin
    result = scaled;
    case (actSel_t'(actFuncSel))
      ACT_ID:    result = scaled;
      ACT_RELU:  result = isNeg ? '0 : scaled;
      ACT_STEP:  result = (!isNeg && !isZero) ? ONE : '0;
      ACT_CLAMP: begin
        if (isNeg) begin
          result = '0;
        end else if (scaled > ONE) begin
          result = ONE;
        end else begin
          result = scaled;
        end
      end
      default:   result = scaled;
    endcase
  end

endmodule

// File: rtl/neuron_op_engine.sv
// Neuron operation engine: gathers N indexed inputs and weights, accumulates the
// Q8.8 dot product, applies an activation and writes one result word to memory.
module neuron_op_engine
  import neuron_op_engine_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beginOp,
  output logic              readyForNextOp,
  output logic              critical,
  input  logic [DATA_W-1:0] offsetReg,
  input  logic [DATA_W-1:0] indexOffsetReg,
  input  logic [DATA_W-1:0] weightOffsetReg,
  input  logic [DATA_W-1:0] numOpsReg,
  input  logic [DATA_W-1:0] destReg,
  input  logic [1:0]        actFuncSelReg,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWrData,
  input  logic [DATA_W-1:0] memRdData,
  output logic              memWE
);

  opState_t state, nextState;

  logic [DATA_W-1:0] offsetQ, indexOffsetQ, weightOffsetQ, numOpsQ, destQ;
  logic [1:0]        actSelQ;

  logic signed [ACC_W-1:0]    acc;
  logic        [DATA_W-1:0]   i;
  logic        [DATA_W-1:0]   iNext;
  logic        [DATA_W-1:0]   idxReg;
  logic        [DATA_W-1:0]   wReg;
  logic        [DATA_W-1:0]   result;
  logic        [DATA_W-1:0]   actOut;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prodExt;

  assign iNext   = i + DATA_W'(1);
  assign prod    = $signed(wReg) * $signed(memRdData);
  assign prodExt = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  activation_unit #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS),
    .ACC_W     (ACC_W)
  ) uAct (
    .acc        (acc),
    .actFuncSel (actSelQ),
    .result     (actOut)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (beginOp) nextState = (numOpsReg == '0) ? S_ACT : S_IDX;
      S_IDX:   nextState = S_WGT;
      S_WGT:   nextState = S_INP;
      S_INP:   nextState = S_MAC;
      S_MAC:   nextState = (iNext == numOpsQ) ? S_ACT : S_IDX;
      S_ACT:   nextState = S_WR;
      S_WR:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Addresses are presented combinationally so the synchronous read returns
  // the word in the following state.
  always_comb begin
    readyForNextOp = (state == IDLE);
    critical       = (state != IDLE);
    memAddr        = '0;
    memWrData      = '0;
    memWE          = 1'b0;
    case (state)
      S_IDX: memAddr = indexOffsetQ + i;
      S_WGT: memAddr = weightOffsetQ + i;
      S_INP: memAddr = offsetQ + idxReg;
      S_WR: begin
        memAddr   = destQ;
        memWrData = result;
        memWE     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offsetQ       <= '0;
      indexOffsetQ  <= '0;
      weightOffsetQ <= '0;
      numOpsQ       <= '0;
      destQ         <= '0;
      actSelQ       <= '0;
      acc           <= '0;
      i             <= '0;
      idxReg        <= '0;
      wReg          <= '0;
      result        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (beginOp) begin
            offsetQ       <= offsetReg;
            indexOffsetQ  <= indexOffsetReg;
            weightOffsetQ <= weightOffsetReg;
            numOpsQ       <= numOpsReg;
            destQ         <= destReg;
            actSelQ       <= actFuncSelReg;
            acc           <= '0;
            i             <= '0;
          end
        end
        S_WGT: idxReg <= memRdData;
        S_INP: wReg   <= memRdData;
        S_MAC: begin
          acc <= acc + prodExt;
          i   <= iNext;
        end
        S_ACT: result <= actOut;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_op_engine.sv
// Directed bench for neuron_op_engine with a synchronous-read memory model and
// a negedge monitor for writes, busy cycles and the presented address sequence.
module tb_neuron_op_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        beginOp = 1'b0;
  logic        readyForNextOp, critical;
  logic [15:0] offsetReg = '0, indexOffsetReg = '0, weightOffsetReg = '0;
  logic [15:0] numOpsReg = '0, destReg = '0;
  logic [1:0]  actFuncSelReg = '0;
  logic [15:0] memAddr, memWrData, memRdData;
  logic        memWE;

  logic [15:0] mem [0:65535];

  neuron_op_engine dut (
    .clk             (clk),
    .rst             (rst),
    .beginOp         (beginOp),
    .readyForNextOp  (readyForNextOp),
    .critical        (critical),
    .offsetReg       (offsetReg),
    .indexOffsetReg  (indexOffsetReg),
    .weightOffsetReg (weightOffsetReg),
    .numOpsReg       (numOpsReg),
    .destReg         (destReg),
    .actFuncSelReg   (actFuncSelReg),
    .memAddr         (memAddr),
    .memWrData       (memWrData),
    .memRdData       (memRdData),
    .memWE           (memWE)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    memRdData <= mem[memAddr];
    if (memWE) mem[memAddr] <= memWrData;
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int          wrCount = 0, critCount = 0, wrCyc = 0;
  logic [15:0] wrAddr = '0, wrData = '0;
  logic [15:0] addrLog [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (memWE) begin
        wrCount = wrCount + 1;
        wrAddr  = memAddr;
        wrData  = memWrData;
        wrCyc   = cyc;
      end
      if (critical) begin
        critCount = critCount + 1;
        addrLog.push_back(memAddr);
      end
    end
  end

  int total = 0;
  int bad   = 0;
  int k     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearMon();
    wrCount   = 0;
    critCount = 0;
    wrCyc     = 0;
    addrLog.delete();
  endtask

  // Accept happens at edge k; config inputs are scrambled right after to show snapshots are used.
  task automatic startOp(input logic [15:0] off, input logic [15:0] idxOff, input logic [15:0] wOff,
                         input logic [15:0] n, input logic [15:0] dst, input logic [1:0] act);
    clearMon();
    @(negedge clk);
    offsetReg       = off;
    indexOffsetReg  = idxOff;
    weightOffsetReg = wOff;
    numOpsReg       = n;
    destReg         = dst;
    actFuncSelReg   = act;
    beginOp         = 1'b1;
    @(posedge clk);
    #1;
    k               = cyc;
    beginOp         = 1'b0;
    offsetReg       = 16'hDEAD;
    indexOffsetReg  = 16'hBEEF;
    weightOffsetReg = 16'hCAFE;
    numOpsReg       = 16'h0007;
    destReg         = 16'hF00D;
    actFuncSelReg   = ~act;
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (!readyForNextOp && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, readyForNextOp}, 32'd1);
  endtask

  task automatic runOp(input string tag, input logic [15:0] off, input logic [15:0] idxOff,
                       input logic [15:0] wOff, input logic [15:0] n, input logic [15:0] dst,
                       input logic [1:0] act, input logic [15:0] expData);
    startOp(off, idxOff, wOff, n, dst, act);
    waitDone(tag);
    check({tag, "_wrCount"}, wrCount, 1);
    check({tag, "_wrAddr"}, {16'd0, wrAddr}, {16'd0, dst});
    check({tag, "_wrData"}, {16'd0, wrData}, {16'd0, expData});
    check({tag, "_wrCyc"}, wrCyc, k + 4 * int'(n) + 1);
    check({tag, "_critCycles"}, critCount, 4 * int'(n) + 2);
    check({tag, "_mem"}, {16'd0, mem[dst]}, {16'd0, expData});
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, readyForNextOp}, 32'd1);
    check("rst_critical", {31'd0, critical}, 32'd0);
    check("rst_memWE", {31'd0, memWE}, 32'd0);
    check("rst_memAddr", {16'd0, memAddr}, 32'd0);
    check("rst_memWrData", {16'd0, memWrData}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single term: 2.0 * 1.5 = 3.0
    mem[16'h0100] = 16'h0002;
    mem[16'h0202] = 16'h0200;
    mem[16'h0300] = 16'h0180;
    runOp("id1", 16'h0200, 16'h0100, 16'h0300, 16'd1, 16'h0400, 2'd0, 16'h0300);

    // 2.0 * -1.0 through ReLU and identity
    mem[16'h0300] = 16'hFF00;
    runOp("relu", 16'h0200, 16'h0100, 16'h0300, 16'd1, 16'h0400, 2'd1, 16'h0000);
    runOp("idneg", 16'h0200, 16'h0100, 16'h0300, 16'd1, 16'h0400, 2'd0, 16'hFE00);

    // Two terms of 127.0 * 2.0: positive overflow of the 16-bit range
    mem[16'h1000] = 16'h0000;
    mem[16'h1001] = 16'h0001;
    mem[16'h1100] = 16'h7F00;
    mem[16'h1101] = 16'h7F00;
    mem[16'h1200] = 16'h0200;
    mem[16'h1201] = 16'h0200;
    runOp("satpos", 16'h1100, 16'h1000, 16'h1200, 16'd2, 16'h1300, 2'd0, 16'h7FFF);
    runOp("clamp", 16'h1100, 16'h1000, 16'h1200, 16'd2, 16'h1300, 2'd3, 16'h0100);
    runOp("steppos", 16'h1100, 16'h1000, 16'h1200, 16'd2, 16'h1300, 2'd2, 16'h0100);
    mem[16'h1200] = 16'hFE00;
    mem[16'h1201] = 16'hFE00;
    runOp("satneg", 16'h1100, 16'h1000, 16'h1200, 16'd2, 16'h1300, 2'd0, 16'h8000);

    // N = 0 writes zero after the activation stage only
    mem[16'h0800] = 16'h5555;
    runOp("n0step", 16'h0000, 16'h0000, 16'h0000, 16'd0, 16'h0800, 2'd2, 16'h0000);
    mem[16'h0800] = 16'h5555;
    runOp("n0id", 16'h0000, 16'h0000, 16'h0000, 16'd0, 16'h0800, 2'd0, 16'h0000);

    // Index table wraps 0xFFFF -> 0x0000; 1.0*2.0 + 3.0*0.5 = 3.5
    mem[16'hFFFF] = 16'h0001;
    mem[16'h0000] = 16'h0002;
    mem[16'h0501] = 16'h0100;
    mem[16'h0502] = 16'h0300;
    mem[16'h0600] = 16'h0200;
    mem[16'h0601] = 16'h0080;
    startOp(16'h0500, 16'hFFFF, 16'h0600, 16'd2, 16'h0700, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    beginOp = 1'b1;
    @(posedge clk);
    #1;
    beginOp = 1'b0;
    waitDone("wrap");
    check("wrap_wrCount", wrCount, 1);
    check("wrap_wrData", {16'd0, wrData}, 32'h0380);
    check("wrap_logLen", addrLog.size(), 10);
    if (addrLog.size() == 10) begin
      check("wrap_idx0", {16'd0, addrLog[0]}, 32'hFFFF);
      check("wrap_wgt0", {16'd0, addrLog[1]}, 32'h0600);
      check("wrap_inp0", {16'd0, addrLog[2]}, 32'h0501);
      check("wrap_idx1", {16'd0, addrLog[4]}, 32'h0000);
      check("wrap_wgt1", {16'd0, addrLog[5]}, 32'h0601);
      check("wrap_inp1", {16'd0, addrLog[6]}, 32'h0502);
      check("wrap_dest", {16'd0, addrLog[9]}, 32'h0700);
    end
    repeat (10) @(negedge clk);
    check("wrap_noRequeue", wrCount, 1);
    check("wrap_idleAfter", {31'd0, readyForNextOp}, 32'd1);

    // Reset during S_INP of the third term of a 4-term operation
    mem[16'h0900] = 16'hBEEF;
    startOp(16'h1100, 16'h1000, 16'h1200, 16'd4, 16'h0900, 2'd0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_memWE", {31'd0, memWE}, 32'd0);
    check("mid_rst_ready", {31'd0, readyForNextOp}, 32'd1);
    check("mid_rst_critical", {31'd0, critical}, 32'd0);
    check("mid_rst_memAddr", {16'd0, memAddr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_rst_noWrite", wrCount, 0);
    check("mid_rst_destKept", {16'd0, mem[16'h0900]}, 32'hBEEF);
    runOp("after_rst", 16'h0200, 16'h0100, 16'h0300, 16'd1, 16'h0900, 2'd0, 16'hFE00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
